// File: rtl/m_ps2_rx.sv
// PS/2 device-to-host receiver: sync + glitch filter on both pins, 11-bit frame deserializer.
// Latency: pin edge to filtered edge is 2+FILTER_LEN cycles; result strobe 1 cycle after the stop-bit edge.
// No backpressure: the consumer must accept w_rx_we whenever it pulses.
module m_ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       CLK,
  input  logic       RST_X,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] w_rx_data,
  output logic       w_rx_we,
  output logic       w_err_parity,
  output logic       w_err_frame,
  output logic       w_busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    FLT_TOP = 8'(FILTER_LEN - 1);
  // r_tmo reads 0 in the cycle after an edge, so hitting TIMEOUT_CYC-2 here puts
  // the registered strobe exactly TIMEOUT_CYC cycles after the edge cycle.
  localparam logic [TW-1:0] TMO_HIT = TW'(TIMEOUT_CYC - 2);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // index 0 = clock line, index 1 = data line
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_flt;
  logic [7:0]    r_fcnt [2];
  logic          r_clk_flt_q;
  logic [TW-1:0] r_tmo;

  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [7:0]    r_rx_data;
  logic          r_rx_we;
  logic          r_err_parity;
  logic          r_err_frame;
  logic          r_busy;

  state_t        w_state_nxt;
  logic [2:0]    w_bit_cnt_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_par_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_we_nxt;
  logic          w_perr_nxt;
  logic          w_ferr_nxt;
  logic          w_fall;
  logic          w_bit;
  logic          w_tmo_hit;

  // Two-stage synchronizer on both raw pins; idle level of the bus is high.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= {ps2_data, ps2_clk};
      r_sync2 <= r_sync1;
    end
  end

  // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_flt     <= 2'b11;
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_flt[i]) begin
          if (r_fcnt[i] == FLT_TOP) begin
            r_flt[i]  <= ~r_flt[i];
            r_fcnt[i] <= '0;
          end else begin
            r_fcnt[i] <= r_fcnt[i] + 8'd1;
          end
        end else begin
          r_fcnt[i] <= '0;
        end
      end
    end
  end

  // Previous filtered clock level for falling-edge detection.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_clk_flt_q <= 1'b1;
    end else begin
      r_clk_flt_q <= r_flt[0];
    end
  end

  assign w_fall    = r_clk_flt_q & ~r_flt[0];
  assign w_bit     = r_flt[1];
  assign w_tmo_hit = (r_state != S_IDLE) && (r_tmo == TMO_HIT);

  // Inter-edge watchdog: cleared by each edge and while idle, saturating otherwise.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_tmo <= '0;
    end else if (w_fall || (r_state == S_IDLE)) begin
      r_tmo <= '0;
    end else if (r_tmo != TMO_MAX) begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  // Frame FSM next-state and result strobes; an edge always beats a timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_par_nxt     = r_par;
    w_data_nxt    = r_rx_data;
    w_we_nxt      = 1'b0;
    w_perr_nxt    = 1'b0;
    w_ferr_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && !w_bit) begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = 3'd0;
          w_shift_nxt   = 8'h00;
        end
      end
      S_DATA: begin
        if (w_fall) begin
          w_shift_nxt   = {w_bit, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (w_fall) begin
          w_par_nxt   = w_bit;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          if (!w_bit) begin
            w_ferr_nxt = 1'b1;
          end else if (^{r_shift, r_par}) begin
            w_we_nxt   = 1'b1;
            w_data_nxt = r_shift;
          end else begin
            w_perr_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!w_fall && w_tmo_hit) begin
      w_state_nxt   = S_IDLE;
      w_bit_cnt_nxt = 3'd0;
      w_shift_nxt   = 8'h00;
      w_par_nxt     = 1'b0;
      w_ferr_nxt    = 1'b1;
    end
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_par        <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_we      <= 1'b0;
      r_err_parity <= 1'b0;
      r_err_frame  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_par        <= w_par_nxt;
      r_rx_data    <= w_data_nxt;
      r_rx_we      <= w_we_nxt;
      r_err_parity <= w_perr_nxt;
      r_err_frame  <= w_ferr_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign w_rx_data    = r_rx_data;
  assign w_rx_we      = r_rx_we;
  assign w_err_parity = r_err_parity;
  assign w_err_frame  = r_err_frame;
  assign w_busy       = r_busy;

endmodule

// File: tb/tb_m_ps2_rx.sv
// Bench for m_ps2_rx: table of frames plus hand sequences for glitch, timeout and reset.
// Strobe timing measured against the pin falling edge that produced it.
// No backpressure on the DUT side; monitor counts every strobe.
module tb_m_ps2_rx;

  localparam int FL   = 8;
  localparam int TMO  = 400;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst_x = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_we;
  logic       err_par;
  logic       err_frm;
  logic       busy;

  m_ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
    .CLK          (clk),
    .RST_X        (rst_x),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .w_rx_data    (rx_data),
    .w_rx_we      (rx_we),
    .w_err_parity (err_par),
    .w_err_frame  (err_frm),
    .w_busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Strobe monitor, sampled on the falling CLK edge.
  int         n_we = 0, n_pe = 0, n_fe = 0;
  logic [7:0] we_dat = 8'h00;
  int         strobe_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
  logic       prev_any = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rst_x) begin
      if (rx_we | err_par | err_frm) begin
        check("strobe_onehot", $countones({rx_we, err_par, err_frm}), 1);
        check("strobe_width", int'(prev_any), 0);
        strobe_cyc = cyc;
      end
      if (rx_we) begin
        n_we++;
        we_dat = rx_data;
      end
      if (err_par) n_pe++;
      if (err_frm) n_fe++;
      if (busy && !prev_busy) busy_rise_cyc = cyc;
      if (!busy && prev_busy) busy_fall_cyc = cyc;
    end
    prev_any  = rx_we | err_par | err_frm;
    prev_busy = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int last_fall = 0;

  // Drive bits[0..nbits-1]; data set at start of the high phase, sampled on the fall.
  // gbit selects a bit whose high phase carries a low glitch of glen cycles.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int gbit, input int glen);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == gbit) begin
        tick(HALF / 2);
        ps2_clk = 1'b0;
        tick(glen);
        ps2_clk = 1'b1;
        tick(HALF - HALF / 2 - glen);
      end else begin
        tick(HALF);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      tick(HALF);
      ps2_clk   = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  int s_we, s_pe, s_fe;
  task automatic snap();
    s_we = n_we;
    s_pe = n_pe;
    s_fe = n_fe;
  endtask

  task automatic verify(input string nm, input int ew, input int ep, input int ef,
                        input logic [7:0] ed);
    check({nm, "_we_cnt"}, n_we - s_we, ew);
    check({nm, "_perr_cnt"}, n_pe - s_pe, ep);
    check({nm, "_ferr_cnt"}, n_fe - s_fe, ef);
    check({nm, "_data"}, int'(rx_data), int'(ed));
    check({nm, "_busy"}, int'(busy), 0);
    if (ew != 0) check({nm, "_data_at_we"}, int'(we_dat), int'(ed));
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    int         ew, ep, ef;
    logic [7:0] ed;
  } vec_t;

  vec_t vt [11];

  initial begin
    vt[0]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
    vt[1]  = '{8'hF0, 1'b1, 1'b1, 1, 0, 0, 8'hF0};
    vt[2]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
    vt[3]  = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'h1C};
    vt[4]  = '{8'h1C, 1'b1, 1'b0, 0, 0, 1, 8'h1C};
    vt[5]  = '{8'h5A, 1'b1, 1'b1, 1, 0, 0, 8'h5A};
    vt[6]  = '{8'h00, 1'b1, 1'b1, 1, 0, 0, 8'h00};
    vt[7]  = '{8'hFF, 1'b1, 1'b1, 1, 0, 0, 8'hFF};
    vt[8]  = '{8'h00, 1'b0, 1'b1, 0, 1, 0, 8'hFF};
    vt[9]  = '{8'hA5, 1'b1, 1'b0, 0, 0, 1, 8'hFF};
    vt[10] = '{8'h80, 1'b0, 1'b1, 1, 0, 0, 8'h80};

    // Reset state
    tick(3);
    check("rst_data", int'(rx_data), 0);
    check("rst_we", int'(rx_we), 0);
    check("rst_perr", int'(err_par), 0);
    check("rst_ferr", int'(err_frm), 0);
    check("rst_busy", int'(busy), 0);
    rst_x = 1'b1;
    tick(5);

    // Good frame with busy/strobe timing, start bit sent on its own
    snap();
    send_bits(frame(8'h1C, 1'b0, 1'b1), 1, -1, 0);
    check("busy_rise_lat", busy_rise_cyc - last_fall, FL + 3);
    send_bits(frame(8'h1C, 1'b0, 1'b1) >> 1, 10, -1, 0);
    tick(20);
    check("strobe_lat", strobe_cyc - last_fall, FL + 3);
    check("busy_fall_with_strobe", busy_fall_cyc, strobe_cyc);
    verify("first", 1, 0, 0, 8'h1C);

    // Table of frames
    for (int v = 0; v < 11; v++) begin
      snap();
      send_bits(frame(vt[v].d, vt[v].par, vt[v].stop), 11, -1, 0);
      tick(20);
      check($sformatf("vec%0d_lat", v), strobe_cyc - last_fall, FL + 3);
      verify($sformatf("vec%0d", v), vt[v].ew, vt[v].ep, vt[v].ef, vt[v].ed);
    end

    // Idle glitch: 5-cycle clock low with data low must not look like a start bit
    snap();
    ps2_data = 1'b0;
    tick(10);
    ps2_clk = 1'b0;
    tick(5);
    ps2_clk = 1'b1;
    tick(30);
    check("idle_glitch_busy", int'(busy), 0);
    ps2_data = 1'b1;
    tick(30);
    verify("idle_glitch", 0, 0, 0, 8'h80);

    // Mid-frame 7-cycle glitch on the clock during bit 4's high phase
    snap();
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 4, 7);
    tick(20);
    verify("mid_glitch", 1, 0, 0, 8'h1C);

    // Timeout after start + 4 data bits
    snap();
    send_bits(frame(8'h5A, 1'b1, 1'b1), 5, -1, 0);
    check("tmo_busy_mid", int'(busy), 1);
    begin
      int k = 0;
      while ((n_fe == s_fe) && (k < TMO + 200)) begin
        tick(1);
        k++;
      end
    end
    tick(2);
    check("tmo_lat", strobe_cyc - last_fall, FL + 2 + TMO);
    verify("tmo", 0, 0, 1, 8'h1C);
    snap();
    send_bits(frame(8'h5A, 1'b1, 1'b1), 11, -1, 0);
    tick(20);
    verify("after_tmo", 1, 0, 0, 8'h5A);

    // Reset mid-frame, then a full frame decodes
    send_bits(frame(8'h1C, 1'b0, 1'b1), 4, -1, 0);
    check("pre_rst_busy", int'(busy), 1);
    rst_x = 1'b0;
    #1;
    check("midrst_data", int'(rx_data), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_strobes", int'({rx_we, err_par, err_frm}), 0);
    tick(3);
    rst_x = 1'b1;
    tick(5);
    snap();
    send_bits(frame(8'h5A, 1'b1, 1'b1), 11, -1, 0);
    tick(20);
    verify("after_rst", 1, 0, 0, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
